alu8_issue_stage: RTL
=====================

Name: alu8_issue_stage

Overview:
- Sequential issue/retire stage wrapped around the 8-bit add/mul/comp/sub combinational datapath.
- Buffers incoming operation requests in a small FIFO and drives registered operands and opcode into the datapath.
- Captures the datapath's 16-bit result into an output register and returns it with a valid/ready handshake and a pass-through tag.
- Decouples the bursty requester from the response consumer; provides back-pressure in both directions.

Parameters:
- FIFO_DEPTH, 4, request FIFO entries; power of two, minimum 2.
- TAG_W, 4, width of the request tag carried alongside each operation.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request FIFO can accept
- req_op  in  2  opcode: 00 add, 01 sub, 10 mul, 11 comp
- req_a  in  8  operand a
- req_b  in  8  operand b
- req_tag  in  TAG_W  requester tag
- dp_a  out  8  registered operand a to datapath
- dp_b  out  8  registered operand b to datapath
- dp_op  out  2  registered opcode to datapath
- dp_result  in  16  combinational datapath result for dp_a/dp_b/dp_op
- rsp_valid  out  1  result register holds a result
- rsp_ready  in  1  consumer accepts result
- rsp_result  out  16  captured result
- rsp_op  out  2  opcode of captured result
- rsp_tag  out  TAG_W  tag of captured result
- occupancy  out  $clog2(FIFO_DEPTH)+1  FIFO entries currently held

Behaviour:
- Reset values (synchronous, highest priority):
  - FIFO empty, occupancy=0, req_ready=1.
  - Issue stage invalid; dp_a=0, dp_b=0, dp_op=0.
  - rsp_valid=0, rsp_result=0, rsp_op=0, rsp_tag=0.
  - Reset asserted mid-operation discards all queued, issued and unconsumed results; no response is produced for them.
- Request side:
  - req_ready = !full; push on req_valid && req_ready.
  - No push when full, even if a pop happens in the same cycle.
  - Request fields are sampled at the push edge.
- Pipeline: FIFO -> issue register (ISS) -> result register (RSP).
  - ISS advances when iss_valid=0 or RSP will be free this cycle.
  - RSP is free this cycle when rsp_valid=0 or (rsp_valid && rsp_ready).
  - On advance with FIFO non-empty: pop head into dp_a/dp_b/dp_op/tag and set iss_valid=1.
  - On advance with FIFO empty: iss_valid=0; dp_* hold their last values.
  - RSP loads {dp_result, dp_op, tag} when iss_valid=1 and RSP is free; rsp_valid=1.
  - If RSP is free with no ISS data, rsp_valid=0.
  - Stall: rsp_valid && !rsp_ready freezes both ISS and RSP; dp_* stay stable so dp_result stays stable.
- Latency: empty pipeline, request pushed at edge T gives ISS at T+1 and rsp_valid=1 after edge T+2.
- Throughput: one result per cycle with rsp_ready tied high.
- Ordering: strictly in order; tags are never reordered.
- Simultaneous push and pop: allowed when not full; occupancy unchanged.
- Wrap-around: read and write pointers wrap modulo FIFO_DEPTH; occupancy distinguishes full from empty.
- rsp_* stay stable while rsp_valid && !rsp_ready.
- Result convention (datapath-defined, checked by bench golden model; this block forwards unmodified):
  - add: {7'b0, carry, sum}.
  - sub: 16-bit two's-complement a-b.
  - mul: 16-bit unsigned a*b.
  - comp: 16'h0001 if a>b, 16'h0002 if a==b, 16'h0000 if a<b.

Test Plan:
- Single op, rsp_ready=1: push add a=200,b=100,tag=3 at T -> rsp_valid after T+2, rsp_result=16'h012C, rsp_op=00, rsp_tag=3, held one cycle.
- Back-to-back mixed ops: sub 5-7, mul 15*17, comp 9 vs 9 on consecutive cycles, rsp_ready=1 -> results 16'hFFFE, 16'h00FF, 16'h0002 on consecutive cycles, in order.
- Full/back-pressure: rsp_ready=0, push 6 requests with FIFO_DEPTH=4 -> FIFO, ISS and RSP fill, 6 accepted, req_ready=0, occupancy=4. Raise rsp_ready -> 6 ordered results, then req_ready returns to 1.
- Stall stability: rsp_ready=0 with a result pending for 5 cycles -> rsp_result, rsp_tag and dp_a/dp_b constant throughout; no result lost.
- Wrap-around: 3*FIFO_DEPTH random ops with random rsp_ready toggling -> every tag 0..11 returned once, in order, matching golden model.
- Reset mid-stream: 3 queued, 1 in ISS, 1 in RSP, assert rst one cycle -> next cycle rsp_valid=0, occupancy=0, req_ready=1; no stale response appears afterward.

Source files
------------

// File: rtl/alu8_issue_stage.sv
// alu8_issue_stage: issue/retire wrapper around the 8-bit add/sub/mul/comp datapath.
// Requests are buffered in a FIFO and popped into an issue register (ISS) that
// drives the datapath operands. The datapath result is then captured into a
// response register (RSP) that is offered to the consumer with valid/ready.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake (req_ready = FIFO not full)
//   req_op/req_a/req_b/req_tag    request payload, sampled at the push edge
//   dp_a/dp_b/dp_op               registered operands/opcode to the datapath
//   dp_result                     combinational datapath result
//   rsp_valid/rsp_ready           response handshake
//   rsp_result/rsp_op/rsp_tag     captured response payload
//   occupancy                     FIFO entries currently held
module alu8_issue_stage #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TAG_W      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [1:0]                    req_op,
  input  logic [7:0]                    req_a,
  input  logic [7:0]                    req_b,
  input  logic [TAG_W-1:0]              req_tag,
  output logic [7:0]                    dp_a,
  output logic [7:0]                    dp_b,
  output logic [1:0]                    dp_op,
  input  logic [15:0]                   dp_result,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [15:0]                   rsp_result,
  output logic [1:0]                    rsp_op,
  output logic [TAG_W-1:0]              rsp_tag,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [1:0]       op;
    logic [7:0]       a;
    logic [7:0]       b;
    logic [TAG_W-1:0] tag;
  } req_t;

  // FIFO storage and control
  req_t             r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Issue stage
  logic             r_iss_valid;
  logic [7:0]       r_dp_a;
  logic [7:0]       r_dp_b;
  logic [1:0]       r_dp_op;
  logic [TAG_W-1:0] r_iss_tag;

  // Response stage
  logic             r_rsp_valid;
  logic [15:0]      r_rsp_result;
  logic [1:0]       r_rsp_op;
  logic [TAG_W-1:0] r_rsp_tag;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_rsp_free;
  logic w_iss_adv;
  req_t w_req_in;
  req_t w_head;

  assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  // Push is gated by the registered count only, so a same-cycle pop never
  // lets a request into a full FIFO.
  assign w_push     = req_valid && !w_full;
  assign w_rsp_free = !r_rsp_valid || rsp_ready;
  assign w_iss_adv  = !r_iss_valid || w_rsp_free;
  assign w_pop      = w_iss_adv && !w_empty;

  assign w_req_in = '{op: req_op, a: req_a, b: req_b, tag: req_tag};
  assign w_head   = r_mem[r_rd_ptr];

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth)
  always_ff @(posedge clk) begin : fifo_ctrl
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // FIFO storage; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin : fifo_mem
    if (w_push) r_mem[r_wr_ptr] <= w_req_in;
  end

  // Issue register; operands hold when the FIFO runs dry so dp_result stays put
  always_ff @(posedge clk) begin : iss_stage
    if (rst) begin
      r_iss_valid <= 1'b0;
      r_dp_a      <= '0;
      r_dp_b      <= '0;
      r_dp_op     <= '0;
      r_iss_tag   <= '0;
    end else if (w_iss_adv) begin
      r_iss_valid <= !w_empty;
      if (!w_empty) begin
        r_dp_a    <= w_head.a;
        r_dp_b    <= w_head.b;
        r_dp_op   <= w_head.op;
        r_iss_tag <= w_head.tag;
      end
    end
  end

  // Response register; frozen while the consumer stalls
  always_ff @(posedge clk) begin : rsp_stage
    if (rst) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_op     <= '0;
      r_rsp_tag    <= '0;
    end else if (w_rsp_free) begin
      r_rsp_valid <= r_iss_valid;
      if (r_iss_valid) begin
        r_rsp_result <= dp_result;
        r_rsp_op     <= r_dp_op;
        r_rsp_tag    <= r_iss_tag;
      end
    end
  end

  assign req_ready  = !w_full;
  assign occupancy  = r_count;
  assign dp_a       = r_dp_a;
  assign dp_b       = r_dp_b;
  assign dp_op      = r_dp_op;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_op     = r_rsp_op;
  assign rsp_tag    = r_rsp_tag;

endmodule
